// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: funct3 codes, FSM states,
// the latched request record and the access-size decode.
package mem_access_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake plus the data-memory port.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MEM_WE;
  logic [2:0]  MEM_FUNCT3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;

  // The unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, MEM_READ_DATA,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MEM_WE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA
  );

  // Core plus data memory surrounding the unit.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, MEM_READ_DATA,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MEM_WE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data extension by funct3; shared with the writeback path.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  // Sign/zero extend from the access width; bits above the width are dropped.
  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'b0, raw[7:0]};
      F3_HU:   result = {16'b0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: range check, single aligned access or byte-serial
// split for misaligned ones, then a one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  mem_access_unit_if.slave bus
);

  state_t      state, nstate;
  req_t        lat;
  logic        err_q;
  logic [1:0]  j;
  logic [31:0] asm_q;

  logic [2:0]  size_in;
  logic        bad_in, aligned_in, accept;
  logic [32:0] last_byte;
  logic [1:0]  last_j;
  logic [31:0] ext;

  logic        mem_we;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr, mem_wd;

  assign bus.req_ready = (state == IDLE) && RST_N;
  assign accept        = bus.req_valid && bus.req_ready;

  // Validity and alignment of the incoming request, used only on the accept edge.
  always_comb begin
    size_in    = size_of(bus.req_funct3);
    last_byte  = {1'b0, bus.req_addr} + {30'b0, size_in} - 33'd1;
    bad_in     = (size_in == 3'd0) || (last_byte >= 33'(MEM_BYTES));
    aligned_in = 1'b1;
    if (size_in == 3'd2) aligned_in = !bus.req_addr[0];
    if (size_in == 3'd4) aligned_in = (bus.req_addr[1:0] == 2'b00);
  end

  // Final byte index of a split, from the latched size (1/2/4 -> 0/1/3).
  assign last_j = 2'(size_of(lat.funct3) - 3'd1);

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = bad_in ? RESP : (aligned_in ? ACCESS : SPLIT);
      ACCESS:  nstate = RESP;
      SPLIT:   if (j == last_j) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // State, latched request, byte counter and load assembly.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      lat   <= '0;
      err_q <= 1'b0;
      j     <= '0;
      asm_q <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (accept) begin
          lat   <= '{we: bus.req_we, funct3: bus.req_funct3,
                     addr: bus.req_addr, wdata: bus.req_wdata};
          err_q <= bad_in;
          j     <= '0;
          asm_q <= '0;
        end
        ACCESS: if (!lat.we) asm_q <= bus.MEM_READ_DATA;
        SPLIT: begin
          if (!lat.we) asm_q[{j, 3'b000} +: 8] <= bus.MEM_READ_DATA[7:0];
          j <= j + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port decoded purely from registered state; quiet in IDLE/RESP.
  always_comb begin
    mem_we   = 1'b0;
    mem_f3   = 3'b000;
    mem_addr = '0;
    mem_wd   = '0;
    case (state)
      ACCESS: begin
        mem_we   = lat.we;
        mem_addr = lat.addr;
        if (lat.we) begin
          mem_f3 = {1'b0, lat.funct3[1:0]};
          case (lat.funct3[1:0])
            2'b00:   mem_wd = {24'b0, lat.wdata[7:0]};
            2'b01:   mem_wd = {16'b0, lat.wdata[15:0]};
            default: mem_wd = lat.wdata;
          endcase
        end else begin
          // Loads always fetch unsigned; extension happens on the response.
          mem_f3 = (lat.funct3[1:0] == 2'b10) ? F3_W : {1'b1, lat.funct3[1:0]};
        end
      end
      SPLIT: begin
        mem_we   = lat.we;
        mem_addr = lat.addr + {30'b0, j};
        mem_f3   = lat.we ? F3_B : F3_BU;
        if (lat.we) mem_wd = {24'b0, lat.wdata[{j, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  assign bus.MEM_WE         = mem_we;
  assign bus.MEM_FUNCT3     = mem_f3;
  assign bus.MEM_ADDRESS    = mem_addr;
  assign bus.MEM_WRITE_DATA = mem_wd;

  load_extend u_ext (
    .raw    (asm_q),
    .funct3 (lat.funct3),
    .result (ext)
  );

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = ((state == RESP) && !err_q && !lat.we) ? ext : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array data memory, directed scenarios and
// random traffic checked against a byte-level reference memory.
module tb_mem_access_unit;

  localparam int MB = 1024;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
  } wr_t;

  bit [7:0]  mem     [MB];
  bit [7:0]  ref_mem [MB];
  wr_t       wlog[$];
  int        we_cnt = 0;
  int        checks = 0;
  int        errors = 0;

  // Data memory: writes on posedge by access size.
  always @(posedge CLK) begin
    if (bus.MEM_WE) begin
      for (int k = 0; k < 4; k++) begin
        if ((k < 1) || (k < 2 && bus.MEM_FUNCT3[1:0] == 2'b01) || (bus.MEM_FUNCT3[1:0] == 2'b10))
          if (bus.MEM_ADDRESS + 32'(k) < 32'(MB))
            mem[bus.MEM_ADDRESS + 32'(k)] <= bus.MEM_WRITE_DATA[8*k +: 8];
      end
      wlog.push_back('{addr: bus.MEM_ADDRESS, f3: bus.MEM_FUNCT3, data: bus.MEM_WRITE_DATA});
      we_cnt <= we_cnt + 1;
    end
  end

  // Combinational read of four bytes; the unit must ignore the ones beyond size.
  always_comb begin
    bus.MEM_READ_DATA = '0;
    for (int k = 0; k < 4; k++) begin
      if (bus.MEM_ADDRESS + 32'(k) < 32'(MB))
        bus.MEM_READ_DATA[8*k +: 8] = mem[bus.MEM_ADDRESS + 32'(k)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return (n == 0) || (longint'(a) + n - 1 >= MB);
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    if (is_bad(f3, a)) return 1;
    if ((a % n) == 0) return 2;
    return n + 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(f3);
    for (int k = 0; k < n; k++) v += longint'(ref_mem[a + 32'(k)]) << (8 * k);
    if (f3 == 3'b000 && v >= 128)   v -= 256;
    if (f3 == 3'b001 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  // Issue one request; report response data/err and accept-to-response latency.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && n < 20) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
    rd = bus.resp_rdata; er = bus.resp_err;
    if (!bus.resp_valid) lat = -1;
    @(posedge CLK); #1;
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic        er;
    int          lat, w0, n;
    bit          bad = is_bad(f3, a);
    n   = nbytes(f3);
    erd = (bad || we) ? 32'd0 : model_load(f3, a);
    w0  = we_cnt;
    do_req(we, f3, a, wd, rd, er, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat(f3, a)));
    chk({tag, ".err"}, {31'b0, er}, {31'b0, bad});
    chk({tag, ".rdata"}, rd, erd);
    if (bad || !we) chk({tag, ".nowrite"}, 32'(we_cnt - w0), 32'd0);
    if (we && !bad)
      for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
  endtask

  logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst.resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst.mem_we", {31'b0, bus.MEM_WE}, 32'd0);
    chk("rst.mem_f3", {29'b0, bus.MEM_FUNCT3}, 32'd0);
    chk("rst.mem_addr", bus.MEM_ADDRESS, 32'd0);
    chk("rst.mem_wdata", bus.MEM_WRITE_DATA, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("rst.ready_after", {31'b0, bus.req_ready}, 32'd1);

    // 1: aligned word store and load.
    wlog.delete();
    op("t1.sw", 1'b1, 3'b010, 32'd0, 32'hAABBCCDD);
    chk("t1.nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("t1.waddr", wlog[0].addr, 32'd0);
      chk("t1.wf3", {29'b0, wlog[0].f3}, 32'h2);
      chk("t1.wdata", wlog[0].data, 32'hAABBCCDD);
    end
    op("t1.lw", 1'b0, 3'b010, 32'd0, 32'h0);
    chk("t1.lw_abs", model_load(3'b010, 32'd0), 32'hAABBCCDD);

    // 2: byte store, signed/unsigned byte loads, word readback.
    op("t2.sb", 1'b1, 3'b000, 32'd1, 32'h123456FF);
    op("t2.lb", 1'b0, 3'b000, 32'd1, 32'h0);
    op("t2.lbu", 1'b0, 3'b100, 32'd1, 32'h0);
    op("t2.lw", 1'b0, 3'b010, 32'd0, 32'h0);
    chk("t2.lw_abs", model_load(3'b010, 32'd0), 32'hAABBFFDD);

    // 3: misaligned word store becomes four byte writes.
    wlog.delete();
    op("t3.sw", 1'b1, 3'b010, 32'd5, 32'h11223344);
    chk("t3.nwr", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t3.waddr%0d", k), wlog[k].addr, 32'(5 + k));
        chk($sformatf("t3.wf3%0d", k), {29'b0, wlog[k].f3}, 32'd0);
        chk($sformatf("t3.wdata%0d", k), {24'b0, wlog[k].data[7:0]}, 32'(8'h44 >> 0) & 0 | 32'({8'h44, 8'h33, 8'h22, 8'h11} >> (24 - 8 * k)) & 32'hFF);
      end
    op("t3.lw", 1'b0, 3'b010, 32'd5, 32'h0);
    chk("t3.lw_abs", model_load(3'b010, 32'd5), 32'h11223344);

    // 4: misaligned half.
    op("t4.sh", 1'b1, 3'b001, 32'd3, 32'h00008001);
    op("t4.lh", 1'b0, 3'b001, 32'd3, 32'h0);
    op("t4.lhu", 1'b0, 3'b101, 32'd3, 32'h0);
    chk("t4.lh_abs", model_load(3'b001, 32'd3), 32'hFFFF8001);

    // 5: errors and range boundaries.
    op("t5.lw1022", 1'b0, 3'b010, 32'd1022, 32'h0);
    op("t5.sw1022", 1'b1, 3'b010, 32'd1022, 32'h12345678);
    op("t5.f3_011", 1'b0, 3'b011, 32'd0, 32'h0);
    op("t5.sh1023", 1'b1, 3'b001, 32'd1023, 32'hBEEF);
    op("t5.sw1020", 1'b1, 3'b010, 32'd1020, 32'hCAFEF00D);
    op("t5.lw1020", 1'b0, 3'b010, 32'd1020, 32'h0);
    op("t5.sb1023", 1'b1, 3'b000, 32'd1023, 32'h5A);
    op("t5.lbu1023", 1'b0, 3'b100, 32'd1023, 32'h0);
    op("t5.lhu1021", 1'b0, 3'b101, 32'd1021, 32'h0);

    // 6: reset in the second byte cycle of a split store.
    wlog.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'd9; bus.req_wdata = 32'hDEADBEEF;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("t6.no_resp%0d", c), {31'b0, bus.resp_valid}, 32'd0);
      chk($sformatf("t6.no_we%0d", c), {31'b0, bus.MEM_WE}, 32'd0);
    end
    chk("t6.ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("t6.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t6.nwr", 32'(wlog.size()), 32'd2);
    ref_mem[9]  = 8'hEF;
    ref_mem[10] = 8'hBE;
    for (int k = 9; k < 13; k++) op($sformatf("t6.lbu%0d", k), 1'b0, 3'b100, 32'(k), 32'h0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [2:0]  f3;
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)      f3 = f3s[$urandom_range(5, 7)];
      else if (we)                        f3 = f3s[$urandom_range(0, 2)];
      else                                f3 = f3s[$urandom_range(0, 4)];
      a = ($urandom_range(0, 7) == 0) ? 32'(1016 + $urandom_range(0, 7)) : 32'($urandom_range(0, 40));
      op($sformatf("rnd%0d", i), we, f3, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
